// File: rtl/con_ff_ext_if.sv
// Signal bundle between the control side and the CON flip-flop: load request,
// condition code, bus value in; registered result and statistics out.
interface con_ff_ext_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  con_in;
  logic [3:0]            ir_cond;
  logic [DATA_WIDTH-1:0] bus_data;
  logic                  stats_clr;
  logic                  con_out;
  logic                  con_valid;
  logic                  cond_ill;
  logic [CNT_WIDTH-1:0]  eval_cnt;
  logic [CNT_WIDTH-1:0]  taken_cnt;

  modport master (
    output con_in, ir_cond, bus_data, stats_clr,
    input  con_out, con_valid, cond_ill, eval_cnt, taken_cnt
  );

  modport slave (
    input  con_in, ir_cond, bus_data, stats_clr,
    output con_out, con_valid, cond_ill, eval_cnt, taken_cnt
  );
endinterface

// File: rtl/con_ff_ext.sv
// Branch-condition flip-flop: evaluates ir_cond against bus_data and registers the
// result on con_in. Optional load/taken statistics enabled by defining CON_STATS_EN.
module con_ff_ext #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic         Clock,
  input  logic         clear,
  con_ff_ext_if.slave  bus
);

  typedef enum logic [3:0] {
    COND_ZERO    = 4'b0000,
    COND_NONZERO = 4'b0001,
    COND_NONNEG  = 4'b0010,
    COND_NEG     = 4'b0011,
    COND_ALWAYS  = 4'b0100,
    COND_NEVER   = 4'b0101,
    COND_GT_ZERO = 4'b0110,
    COND_LE_ZERO = 4'b0111,
    COND_ODD     = 4'b1000,
    COND_EVEN    = 4'b1001
  } cond_e;

  logic is_zero;
  logic is_neg;
  logic cond_result;
  logic cond_reserved;

  assign is_zero = (bus.bus_data == '0);
  assign is_neg  = bus.bus_data[DATA_WIDTH-1];

  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
    cond_result   = 1'b0;
    cond_reserved = 1'b0;
    case (bus.ir_cond)
      COND_ZERO:    cond_result = is_zero;
      COND_NONZERO: cond_result = !is_zero;
      COND_NONNEG:  cond_result = !is_neg;
      COND_NEG:     cond_result = is_neg;
      COND_ALWAYS:  cond_result = 1'b1;
      COND_NEVER:   cond_result = 1'b0;
      COND_GT_ZERO: cond_result = !is_neg && !is_zero;
      COND_LE_ZERO: cond_result = is_neg || is_zero;
      COND_ODD:     cond_result = bus.bus_data[0];
      COND_EVEN:    cond_result = !bus.bus_data[0];
      default:      cond_reserved = 1'b1;
    endcase
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge Clock) begin
    if (clear) begin
      bus.con_out   <= 1'b0;
      bus.con_valid <= 1'b0;
      bus.cond_ill  <= 1'b0;
    end else begin
      bus.con_valid <= bus.con_in;
      if (bus.con_in) begin
        bus.con_out  <= cond_result;
        bus.cond_ill <= cond_reserved;
      end
    end
  end

`ifdef CON_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // stats_clr outranks a simultaneous load, so that load goes uncounted.
  always_ff @(posedge Clock) begin
    if (clear || bus.stats_clr) begin
      bus.eval_cnt  <= '0;
      bus.taken_cnt <= '0;
    end else if (bus.con_in) begin
      if (bus.eval_cnt != '1) begin
        bus.eval_cnt <= bus.eval_cnt + CNT_ONE;
      end
      if (cond_result && (bus.taken_cnt != '1)) begin
        bus.taken_cnt <= bus.taken_cnt + CNT_ONE;
      end
    end
  end
`else
  logic unused_stats_clr;

  assign unused_stats_clr = bus.stats_clr;
  assign bus.eval_cnt     = '0;
  assign bus.taken_cnt    = '0;
`endif

endmodule

// File: tb/tb_con_ff_ext.sv
// Directed bench for con_ff_ext: a per-cycle vector table plus hand-written
// hold and statistics sequences.
module tb_con_ff_ext;

  localparam int DW = 32;
  localparam int CW = 4;

  logic Clock;
  logic clear;

  con_ff_ext_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) cif ();

  con_ff_ext #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (cif.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic          clr;
    logic          ld;
    logic [3:0]    cond;
    logic [DW-1:0] data;
    logic          exp_out;
    logic          exp_valid;
    logic          exp_ill;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic clr, input logic ld, input logic [3:0] cond,
                      input logic [DW-1:0] data, input logic sclr);
    clear         = clr;
    cif.con_in    = ld;
    cif.ir_cond   = cond;
    cif.bus_data  = data;
    cif.stats_clr = sclr;
    @(posedge Clock);
    #1;
  endtask

  vec_t vecs[17];

  initial begin
    clear         = 1'b1;
    cif.con_in    = 1'b0;
    cif.ir_cond   = 4'b0000;
    cif.bus_data  = '0;
    cif.stats_clr = 1'b0;

    //          clr   ld    cond     data           out   valid ill
    vecs[0]  = '{1'b1, 1'b1, 4'b0100, 32'd0,         1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 4'b0100, 32'd0,         1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'b0000, 32'd0,         1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'b0001, 32'd0,         1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'b0010, 32'd10,        1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 4'b0010, 32'hFFFFFFF6,  1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 4'b0011, 32'hFFFFFFF6,  1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'b0110, 32'd0,         1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'b0111, 32'd0,         1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'b1000, 32'd7,         1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 4'b1001, 32'd7,         1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 4'b0101, 32'd1,         1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 4'b1100, 32'd0,         1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 4'b0100, 32'd0,         1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 4'b0110, 32'd5,         1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 4'b0111, 32'd5,         1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 4'b0100, 32'd0,         1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].clr, vecs[i].ld, vecs[i].cond, vecs[i].data, 1'b0);
      check($sformatf("vec%0d con_out", i),   {31'd0, cif.con_out},   {31'd0, vecs[i].exp_out});
      check($sformatf("vec%0d con_valid", i), {31'd0, cif.con_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d cond_ill", i),  {31'd0, cif.cond_ill},  {31'd0, vecs[i].exp_ill});
      if (vecs[i].clr) begin
        check($sformatf("vec%0d eval_cnt", i),  {28'd0, cif.eval_cnt},  32'd0);
        check($sformatf("vec%0d taken_cnt", i), {28'd0, cif.taken_cnt}, 32'd0);
      end
    end

    // Hold: result must survive five idle cycles of changing inputs.
    step(1'b0, 1'b1, 4'b0011, 32'hFFFFFFF6, 1'b0);
    check("hold load con_out", {31'd0, cif.con_out}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      logic [3:0] sweep_cond [5];
      sweep_cond = '{4'b0000, 4'b0101, 4'b1100, 4'b0110, 4'b0001};
      step(1'b0, 1'b0, sweep_cond[i], 32'd1 << i, 1'b0);
      check($sformatf("hold%0d con_out", i),   {31'd0, cif.con_out},   32'd1);
      check($sformatf("hold%0d con_valid", i), {31'd0, cif.con_valid}, 32'd0);
      check($sformatf("hold%0d cond_ill", i),  {31'd0, cif.cond_ill},  32'd0);
    end

    // Statistics: one untaken load, then saturate, then clear alongside a load.
    step(1'b1, 1'b0, 4'b0000, 32'd0, 1'b0);
    step(1'b0, 1'b1, 4'b0101, 32'd0, 1'b0);
`ifdef CON_STATS_EN
    check("stats untaken eval_cnt",  {28'd0, cif.eval_cnt},  32'd1);
    check("stats untaken taken_cnt", {28'd0, cif.taken_cnt}, 32'd0);
`else
    check("nostats eval_cnt",  {28'd0, cif.eval_cnt},  32'd0);
    check("nostats taken_cnt", {28'd0, cif.taken_cnt}, 32'd0);
`endif
    step(1'b1, 1'b0, 4'b0000, 32'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 4'b0100, 32'd0, 1'b0);
      if (i == 4) begin
`ifdef CON_STATS_EN
        check("stats 5 loads eval_cnt", {28'd0, cif.eval_cnt}, 32'd5);
`else
        check("nostats 5 loads eval_cnt", {28'd0, cif.eval_cnt}, 32'd0);
`endif
      end
    end
    check("stats back-to-back con_valid", {31'd0, cif.con_valid}, 32'd1);
`ifdef CON_STATS_EN
    check("stats sat eval_cnt",  {28'd0, cif.eval_cnt},  32'd15);
    check("stats sat taken_cnt", {28'd0, cif.taken_cnt}, 32'd15);
`else
    check("nostats sat eval_cnt",  {28'd0, cif.eval_cnt},  32'd0);
    check("nostats sat taken_cnt", {28'd0, cif.taken_cnt}, 32'd0);
`endif
    step(1'b0, 1'b0, 4'b0101, 32'd0, 1'b0);
    check("pre-clr con_out", {31'd0, cif.con_out}, 32'd1);
    step(1'b0, 1'b1, 4'b0100, 32'd0, 1'b1);
    check("stats_clr eval_cnt",  {28'd0, cif.eval_cnt},  32'd0);
    check("stats_clr taken_cnt", {28'd0, cif.taken_cnt}, 32'd0);
    check("stats_clr con_out",   {31'd0, cif.con_out},   32'd1);
    check("stats_clr con_valid", {31'd0, cif.con_valid}, 32'd1);
    step(1'b0, 1'b0, 4'b0000, 32'd0, 1'b0);
    check("post-clr eval_cnt", {28'd0, cif.eval_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
